// File: rtl/instr_fetch_unit.sv
// Assembles a 32-bit little-endian instruction from four byte reads; result ready 5 cycles after start with zero wait states.
// Memory stalls via mem_ack (each missing ack adds a cycle); start is ignored while busy, and flush aborts the fetch.
module instr_fetch_unit #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic                  i_flush,
    input  logic [ADDR_WIDTH-1:0] i_pc,
    output logic                  o_mem_req,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    input  logic [7:0]            i_mem_rdata,
    input  logic                  i_mem_ack,
    output logic [31:0]           o_instr,
    output logic [5:0]            o_op,
    output logic                  o_instr_valid,
    output logic                  o_busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_VALID = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [ADDR_WIDTH-1:0] w_base_nxt;
    logic [1:0]            r_cnt;
    logic [1:0]            w_cnt_nxt;
    logic [31:0]           r_instr;
    logic [31:0]           w_instr_nxt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_base  <= '0;
            r_cnt   <= 2'd0;
            r_instr <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_base  <= w_base_nxt;
            r_cnt   <= w_cnt_nxt;
            r_instr <= w_instr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_base_nxt  = r_base;
        w_cnt_nxt   = r_cnt;
        w_instr_nxt = r_instr;
        case (r_state)
            S_IDLE: begin
                if (i_start && !i_flush) begin
                    w_state_nxt = S_FETCH;
                    w_base_nxt  = i_pc;
                    w_cnt_nxt   = 2'd0;
                end
            end
            S_FETCH: begin
                // flush wins over a same-cycle ack: that byte is dropped
                if (i_flush) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 2'd0;
                end else if (i_mem_ack) begin
                    w_instr_nxt[{r_cnt, 3'b000} +: 8] = i_mem_rdata;
                    if (r_cnt == 2'd3) begin
                        w_state_nxt = S_VALID;
                    end else begin
                        w_cnt_nxt = r_cnt + 2'd1;
                    end
                end
            end
            S_VALID: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 2'd0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 2'd0;
            end
        endcase
    end

    assign o_mem_addr    = r_base + {{(ADDR_WIDTH-2){1'b0}}, r_cnt};
    assign o_mem_req     = (r_state == S_FETCH);
    assign o_instr_valid = (r_state == S_VALID);
    assign o_busy        = (r_state != S_IDLE);
    assign o_instr       = r_instr;
    assign o_op          = r_instr[31:26];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed and randomized fetches checked against a byte-memory model of the fetch unit.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset, start, flush, mem_ack;
    logic [7:0]  pc, mem_rdata;
    logic        mem_req, instr_valid, busy;
    logic [7:0]  mem_addr;
    logic [31:0] instr;
    logic [5:0]  op;

    logic [7:0]  mem [0:255];
    logic [31:0] exp_instr;
    int          n_chk;
    int          n_pass;
    int          cyc;

    instr_fetch_unit #(.ADDR_WIDTH(8)) dut (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_flush(flush), .i_pc(pc),
        .o_mem_req(mem_req), .o_mem_addr(mem_addr), .i_mem_rdata(mem_rdata),
        .i_mem_ack(mem_ack), .o_instr(instr), .o_op(op),
        .o_instr_valid(instr_valid), .o_busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_req"}, {31'd0, mem_req}, 32'd0);
        chk({tag, "_vld"}, {31'd0, instr_valid}, 32'd0);
    endtask

    // Called at an idle cycle; returns in the idle cycle after the fetch ends.
    // flush_k in 0..3 asserts flush together with the ack of byte flush_k.
    task automatic fetch(input logic [7:0] fpc, input int dly, input int flush_k);
        int          t0;
        logic [7:0]  a;
        start = 1'b1;
        pc    = fpc;
        t0    = cyc;
        step();
        pc = 8'($urandom);
        for (int k = 0; k < 4; k++) begin
            a = fpc + 8'(k);
            for (int w = 0; w <= dly; w++) begin
                chk("fetch_req", {31'd0, mem_req}, 32'd1);
                chk("fetch_addr", {24'd0, mem_addr}, {24'd0, a});
                chk("fetch_busy", {31'd0, busy}, 32'd1);
                chk("fetch_vld", {31'd0, instr_valid}, 32'd0);
                start     = 1'($urandom);
                mem_rdata = mem[a];
                mem_ack   = (w == dly);
                flush     = (w == dly) && (k == flush_k);
                step();
                mem_ack   = 1'b0;
                mem_rdata = 8'($urandom);
                start     = 1'b0;
                if (flush) begin
                    flush = 1'b0;
                    chk_idle("flush");
                    chk("flush_instr", instr, exp_instr);
                    return;
                end
            end
            exp_instr[8*k +: 8] = mem[a];
        end
        chk("valid_pulse", {31'd0, instr_valid}, 32'd1);
        chk("valid_lat", cyc - t0, 32'(5 + 4 * dly));
        chk("valid_instr", instr, exp_instr);
        chk("valid_op", {26'd0, op}, {26'd0, exp_instr[31:26]});
        chk("valid_req", {31'd0, mem_req}, 32'd0);
        start   = 1'b1;
        pc      = 8'($urandom);
        mem_ack = 1'b1;
        step();
        start   = 1'b0;
        mem_ack = 1'b0;
        chk_idle("post_valid");
    endtask

    initial begin
        n_chk = 0; n_pass = 0; cyc = 0;
        exp_instr = 32'd0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'h10] = 8'h78; mem[8'h11] = 8'h56; mem[8'h12] = 8'h34; mem[8'h13] = 8'h12;
        reset = 1'b1; start = 1'b0; flush = 1'b0; mem_ack = 1'b0;
        pc = 8'h00; mem_rdata = 8'h00;
        step(); step();
        reset = 1'b0;
        chk_idle("reset");
        chk("reset_addr", {24'd0, mem_addr}, 32'd0);
        chk("reset_instr", instr, 32'd0);
        chk("reset_op", {26'd0, op}, 32'd0);

        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk_idle("idle_ack");

        fetch(8'h10, 0, -1);
        chk("known_instr", instr, 32'h12345678);
        chk("known_op", {26'd0, op}, 32'h04);

        fetch(8'h20, 2, -1);
        fetch(8'hFE, 0, -1);
        fetch(8'h30, 1, 2);

        start = 1'b1; flush = 1'b1;
        step();
        start = 1'b0; flush = 1'b0;
        chk_idle("flush_idle");
        step();
        chk_idle("flush_idle2");

        fetch(8'h00, 0, -1);
        fetch(8'h04, 0, -1);

        pc = 8'h40; start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_instr = 32'd0;
        chk_idle("mid_reset");
        chk("mid_reset_addr", {24'd0, mem_addr}, 32'd0);
        chk("mid_reset_instr", instr, 32'd0);

        for (int n = 0; n < 12; n++) begin
            int fk;
            fk = int'($urandom_range(0, 6));
            fetch(8'($urandom), int'($urandom_range(0, 3)), (fk > 3) ? -1 : fk);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
